// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Package : router_pkg
// Purpose : Shared types, header bit positions and routing helpers for the
//           mesh-corner router (corner_router) and its output-port block.
// Revision: 1.0  initial release
// ============================================================================
package router_pkg;

  // Router placement kinds. Only the four corners are instanced today; the
  // edge and centre kinds fall back to the coordinate-based mesh check.
  typedef enum logic [3:0] {
    CORNERSW,
    CORNERSE,
    CORNERNW,
    CORNERNE,
    EDGES,
    EDGEN,
    EDGEW,
    EDGEE,
    CENTRE
  } rtype_t;

  // Header occupies the top HDR_W bits of a flit; indices below are offsets
  // inside that header field (add n-HDR_W for the absolute flit bit).
  localparam int HDR_W  = 4;
  localparam int DX_BIT = 3;
  localparam int DY_BIT = 2;
  localparam int XS_BIT = 1;
  localparam int YS_BIT = 0;

  // Port numbering shared by inputs and outputs.
  localparam int         NPORTS  = 4;
  localparam logic [1:0] P_PROC  = 2'd0;
  localparam logic [1:0] P_X     = 2'd1;
  localparam logic [1:0] P_Y     = 2'd2;
  localparam logic [1:0] P_SPARE = 2'd3;

  // Per-output handshake state.
  typedef enum logic [1:0] {
    OUT_IDLE = 2'd0,
    OUT_SEND = 2'd1,
    OUT_WAIT = 2'd2
  } out_state_t;

  function automatic logic is_corner(input rtype_t rt);
    return (rt == CORNERSW) || (rt == CORNERSE) ||
           (rt == CORNERNW) || (rt == CORNERNE);
  endfunction

  // True when a one-hop move in the given dimension and sign stays on the
  // mesh. sign=1 means toward increasing index. Corners additionally pin
  // the only legal inward direction from their kind.
  function automatic logic move_ok(input rtype_t rt, input logic is_x,
                                   input logic sign, input int src,
                                   input int maxc);
    logic ok;
    ok = sign ? (src < maxc) : (src > 0);
    case (rt)
      CORNERSW: ok = ok && sign;
      CORNERSE: ok = ok && (is_x ? !sign : sign);
      CORNERNW: ok = ok && (is_x ? sign : !sign);
      CORNERNE: ok = ok && !sign;
      default:  ok = ok;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/RTPort.sv
`default_nettype none
// ============================================================================
// Interface: RTPort
// Purpose  : One direction of a transition-signalled req/ack link.
//            A new flit is announced by toggling req; the receiver
//            consumes it by toggling ack. data is stable in between.
// Modports : Input  - receiver side (req, data in; ack out)
//            Output - sender side   (req, data out; ack in)
// Revision : 1.0  initial release
// ============================================================================
interface RTPort #(
  parameter int n = 32
);
  logic         req;
  logic         ack;
  logic [n-1:0] data;

  modport Input  (input  req, input  data, output ack);
  modport Output (output req, output data, input  ack);
endinterface
`default_nettype wire

// File: rtl/rt_out_port.sv
`default_nettype none
// ============================================================================
// Module  : rt_out_port
// Purpose : One router output: round-robin arbiter over the four inputs and
//           the two-phase req/ack sender FSM for the outgoing link.
// Ports   : clk, rst      clock, async active-high reset
//           req_vec_i     per-input request for this output
//           flit_i        per-input flit as it should leave this router
//           ack_i         raw (unsynchronised) ack from the downstream node
//           req_o, data_o outgoing link req (transition) and data
//           done_o        one-hot pulse naming the input whose flit was acked
// Revision: 1.0  initial release
// ============================================================================
module rt_out_port
  import router_pkg::*;
#(
  parameter int n = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NPORTS-1:0]            req_vec_i,
  input  logic [NPORTS-1:0][n-1:0]     flit_i,
  input  logic                         ack_i,
  output logic                         req_o,
  output logic [n-1:0]                 data_o,
  output logic [NPORTS-1:0]            done_o
);

  out_state_t   state_q, state_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [1:0]   owner_q, owner_d;
  logic [n-1:0] data_q, data_d;
  logic         req_q, req_d;
  logic         ack_s1_q, ack_s2_q;
  logic         ack_seen_q, ack_seen_d;

  logic         found_w;
  logic [1:0]   win_w;
  logic [1:0]   idx_w;

  // Search starts at the pointer and wraps, so the input after the last
  // winner has highest priority.
  always_comb begin
    found_w = 1'b0;
    win_w   = ptr_q;
    idx_w   = ptr_q;
    for (int k = 0; k < NPORTS; k++) begin
      idx_w = ptr_q + 2'(k);
      if (!found_w && req_vec_i[idx_w]) begin
        found_w = 1'b1;
        win_w   = idx_w;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    data_d     = data_q;
    req_d      = req_q;
    ack_seen_d = ack_seen_q;
    done_o     = '0;
    case (state_q)
      OUT_IDLE: begin
        if (found_w) begin
          data_d  = flit_i[win_w];
          owner_d = win_w;
          ptr_d   = win_w + 2'd1;
          state_d = OUT_SEND;
        end
      end
      OUT_SEND: begin
        // Data was registered last cycle, so it is already stable here.
        req_d   = ~req_q;
        state_d = OUT_WAIT;
      end
      OUT_WAIT: begin
        if (ack_s2_q != ack_seen_q) begin
          ack_seen_d       = ack_s2_q;
          done_o[owner_q]  = 1'b1;
          state_d          = OUT_IDLE;
        end
      end
      default: state_d = OUT_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= OUT_IDLE;
      ptr_q      <= P_PROC;
      owner_q    <= 2'd0;
      data_q     <= '0;
      req_q      <= 1'b0;
      ack_s1_q   <= 1'b0;
      ack_s2_q   <= 1'b0;
      ack_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      data_q     <= data_d;
      req_q      <= req_d;
      ack_s1_q   <= ack_i;
      ack_s2_q   <= ack_s1_q;
      ack_seen_q <= ack_seen_d;
    end
  end

  assign req_o  = req_q;
  assign data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/corner_router.sv
`default_nettype none
// ============================================================================
// Module  : corner_router
// Purpose : Mesh-corner router node. Four two-phase links (proc, X, Y,
//           spare) with X-then-Y dimension-order routing from the flit
//           header; off-mesh moves are acked and dropped.
// Ports   : clk, rst                      clock, async active-high reset
//           proc_input / proc_output      local processor link pair
//           port1_input / port1_output    X-neighbour link pair
//           port2_input / port2_output    Y-neighbour link pair
//           port3_input / port3_output    spare link pair
// Revision: 1.0  initial release
// ============================================================================
module corner_router
  import router_pkg::*;
#(
  parameter rtype_t rtype = CORNERSW,
  parameter int     n     = 32,
  parameter int     srcx  = 0,
  parameter int     srcy  = 0,
  parameter int     maxx  = 1,
  parameter int     maxy  = 1
) (
  input  logic  clk,
  input  logic  rst,
  RTPort.Input  proc_input,
  RTPort.Output proc_output,
  RTPort.Input  port1_input,
  RTPort.Output port1_output,
  RTPort.Input  port2_input,
  RTPort.Output port2_output,
  RTPort.Input  port3_input,
  RTPort.Output port3_output
);

  localparam int DXI = n - HDR_W + DX_BIT;
  localparam int DYI = n - HDR_W + DY_BIT;
  localparam int XSI = n - HDR_W + XS_BIT;
  localparam int YSI = n - HDR_W + YS_BIT;

  // Link signals gathered into port-indexed vectors (0=proc .. 3=spare).
  logic [NPORTS-1:0]        in_req_w;
  logic [NPORTS-1:0][n-1:0] in_data_w;
  logic [NPORTS-1:0]        out_ack_w;
  logic [NPORTS-1:0]        out_req_w;
  logic [NPORTS-1:0][n-1:0] out_data_w;

  assign in_req_w  = {port3_input.req, port2_input.req, port1_input.req, proc_input.req};
  assign in_data_w = {port3_input.data, port2_input.data, port1_input.data, proc_input.data};
  assign out_ack_w = {port3_output.ack, port2_output.ack, port1_output.ack, proc_output.ack};

  assign proc_output.req   = out_req_w[P_PROC];
  assign proc_output.data  = out_data_w[P_PROC];
  assign port1_output.req  = out_req_w[P_X];
  assign port1_output.data = out_data_w[P_X];
  assign port2_output.req  = out_req_w[P_Y];
  assign port2_output.data = out_data_w[P_Y];
  assign port3_output.req  = out_req_w[P_SPARE];
  assign port3_output.data = out_data_w[P_SPARE];

  // Input-side state.
  logic [NPORTS-1:0]        req_s1_q, req_s2_q;
  logic [NPORTS-1:0]        req_seen_q, req_seen_d;
  logic [NPORTS-1:0]        pend_q, pend_d;
  logic [NPORTS-1:0]        in_ack_q, in_ack_d;
  logic [NPORTS-1:0][n-1:0] flit_q, flit_d;

  assign proc_input.ack  = in_ack_q[P_PROC];
  assign port1_input.ack = in_ack_q[P_X];
  assign port2_input.ack = in_ack_q[P_Y];
  assign port3_input.ack = in_ack_q[P_SPARE];

  // Routing decision for each held flit.
  logic [NPORTS-1:0][1:0]        dest_w;
  logic [NPORTS-1:0]             drop_w;
  logic [NPORTS-1:0][n-1:0]      fwd_flit_w;
  logic [NPORTS-1:0][NPORTS-1:0] out_rv_w;    // [output][input]
  logic [NPORTS-1:0][NPORTS-1:0] out_done_w;  // [output][input]
  logic [NPORTS-1:0]             in_done_w;

  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      fwd_flit_w[i] = flit_q[i];
      dest_w[i]     = P_PROC;
      drop_w[i]     = 1'b0;
      if (flit_q[i][DXI]) begin
        dest_w[i]          = P_X;
        fwd_flit_w[i][DXI] = 1'b0;
        drop_w[i]          = !move_ok(rtype, 1'b1, flit_q[i][XSI], srcx, maxx);
      end else if (flit_q[i][DYI]) begin
        dest_w[i]          = P_Y;
        fwd_flit_w[i][DYI] = 1'b0;
        drop_w[i]          = !move_ok(rtype, 1'b0, flit_q[i][YSI], srcy, maxy);
      end
    end
  end

  // Held flits stay requesting until their output reports the downstream
  // ack; the output only samples requests while idle, so this is safe.
  always_comb begin
    for (int o = 0; o < NPORTS; o++) begin
      for (int i = 0; i < NPORTS; i++) begin
        out_rv_w[o][i] = pend_q[i] && !drop_w[i] && (dest_w[i] == 2'(o)) &&
                         !((2'(o) == P_SPARE) && is_corner(rtype));
      end
    end
  end

  always_comb begin
    in_done_w = '0;
    for (int o = 0; o < NPORTS; o++) begin
      in_done_w = in_done_w | out_done_w[o];
    end
  end

  always_comb begin
    req_seen_d = req_seen_q;
    pend_d     = pend_q;
    in_ack_d   = in_ack_q;
    flit_d     = flit_q;
    for (int i = 0; i < NPORTS; i++) begin
      if (!pend_q[i]) begin
        // Edges are only looked at while the input is empty, which holds
        // off the next flit until this one's ack has gone out.
        if (req_s2_q[i] != req_seen_q[i]) begin
          req_seen_d[i] = req_s2_q[i];
          flit_d[i]     = in_data_w[i];
          pend_d[i]     = 1'b1;
        end
      end else if (drop_w[i] || in_done_w[i]) begin
        pend_d[i]   = 1'b0;
        in_ack_d[i] = ~in_ack_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_s1_q   <= '0;
      req_s2_q   <= '0;
      req_seen_q <= '0;
      pend_q     <= '0;
      in_ack_q   <= '0;
      flit_q     <= '0;
    end else begin
      req_s1_q   <= in_req_w;
      req_s2_q   <= req_s1_q;
      req_seen_q <= req_seen_d;
      pend_q     <= pend_d;
      in_ack_q   <= in_ack_d;
      flit_q     <= flit_d;
    end
  end

  for (genvar g = 0; g < NPORTS; g++) begin : g_out
    rt_out_port #(
      .n(n)
    ) u_out (
      .clk       (clk),
      .rst       (rst),
      .req_vec_i (out_rv_w[g]),
      .flit_i    (fwd_flit_w),
      .ack_i     (out_ack_w[g]),
      .req_o     (out_req_w[g]),
      .data_o    (out_data_w[g]),
      .done_o    (out_done_w[g])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_corner_router.sv
`default_nettype none
// ============================================================================
// Module  : tb_corner_router
// Purpose : Self-checking bench for corner_router, configured as the NE
//           corner (1,1) of a 2x2 mesh so that negative-sign moves are the
//           on-mesh ones and positive-sign moves leave the mesh.
// Revision: 1.0  initial release
// ============================================================================
module tb_corner_router;
  import router_pkg::*;

  localparam int N    = 32;
  localparam int SRCX = 1;
  localparam int SRCY = 1;
  localparam int MAXX = 1;
  localparam int MAXY = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  RTPort #(.n(N)) proc_in_if ();
  RTPort #(.n(N)) proc_out_if ();
  RTPort #(.n(N)) p1_in_if ();
  RTPort #(.n(N)) p1_out_if ();
  RTPort #(.n(N)) p2_in_if ();
  RTPort #(.n(N)) p2_out_if ();
  RTPort #(.n(N)) p3_in_if ();
  RTPort #(.n(N)) p3_out_if ();

  corner_router #(
    .rtype(CORNERNE), .n(N), .srcx(SRCX), .srcy(SRCY), .maxx(MAXX), .maxy(MAXY)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .proc_input   (proc_in_if),
    .proc_output  (proc_out_if),
    .port1_input  (p1_in_if),
    .port1_output (p1_out_if),
    .port2_input  (p2_in_if),
    .port2_output (p2_out_if),
    .port3_input  (p3_in_if),
    .port3_output (p3_out_if)
  );

  logic [3:0]  tb_in_req;
  logic [3:0]  tb_out_ack;
  logic [31:0] tb_in_data [4];
  logic [3:0]  in_ack_w;
  logic [3:0]  out_req_w;
  logic [31:0] out_data_w [4];

  assign proc_in_if.req  = tb_in_req[0];
  assign proc_in_if.data = tb_in_data[0];
  assign p1_in_if.req    = tb_in_req[1];
  assign p1_in_if.data   = tb_in_data[1];
  assign p2_in_if.req    = tb_in_req[2];
  assign p2_in_if.data   = tb_in_data[2];
  assign p3_in_if.req    = tb_in_req[3];
  assign p3_in_if.data   = tb_in_data[3];
  assign proc_out_if.ack = tb_out_ack[0];
  assign p1_out_if.ack   = tb_out_ack[1];
  assign p2_out_if.ack   = tb_out_ack[2];
  assign p3_out_if.ack   = tb_out_ack[3];

  assign in_ack_w      = {p3_in_if.ack, p2_in_if.ack, p1_in_if.ack, proc_in_if.ack};
  assign out_req_w     = {p3_out_if.req, p2_out_if.req, p1_out_if.req, proc_out_if.req};
  assign out_data_w[0] = proc_out_if.data;
  assign out_data_w[1] = p1_out_if.data;
  assign out_data_w[2] = p2_out_if.data;
  assign out_data_w[3] = p3_out_if.data;

  int checks   = 0;
  int failures = 0;
  logic [3:0] in_ack_seen  = '0;
  logic [3:0] out_req_seen = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference routing: X first, then Y, else local; a move whose sign
  // points outside 0..max from this router's coordinates is dropped.
  function automatic void route_model(input logic [31:0] f, output int dest,
                                      output logic [31:0] of, output bit drop);
    of   = f;
    drop = 1'b0;
    dest = 0;
    if (f[31]) begin
      dest   = 1;
      of[31] = 1'b0;
      drop   = f[29] ? !(SRCX < MAXX) : !(SRCX > 0);
    end else if (f[30]) begin
      dest   = 2;
      of[30] = 1'b0;
      drop   = f[28] ? !(SRCY < MAXY) : !(SRCY > 0);
    end
  endfunction

  task automatic wait_out(input int p, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (out_req_w[p] !== out_req_seen[p]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_in_ack(input int p, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (in_ack_w[p] !== in_ack_seen[p]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // One complete transfer from input src, checked end to end.
  task automatic xfer(input int src, input logic [31:0] f, input string tag);
    int          dest;
    logic [31:0] ef;
    bit          drop;
    bit          ok;
    route_model(f, dest, ef, drop);
    @(negedge clk);
    tb_in_data[src] = f;
    tb_in_req[src]  = ~tb_in_req[src];
    if (drop) begin
      wait_in_ack(src, ok);
      check($sformatf("%s_drop_ack", tag), 32'(ok), 32'd1);
      repeat (8) @(negedge clk);
      check($sformatf("%s_drop_noreq", tag), 32'(out_req_w), 32'(out_req_seen));
    end else begin
      wait_out(dest, ok);
      check($sformatf("%s_req_p%0d", tag, dest), 32'(ok), 32'd1);
      check($sformatf("%s_reqvec", tag), 32'(out_req_w), 32'(out_req_seen ^ (4'b0001 << dest)));
      check($sformatf("%s_data", tag), out_data_w[dest], ef);
      check($sformatf("%s_early_ack", tag), 32'(in_ack_w), 32'(in_ack_seen));
      out_req_seen[dest] = ~out_req_seen[dest];
      repeat ($urandom_range(0, 4)) @(negedge clk);
      tb_out_ack[dest] = ~tb_out_ack[dest];
      wait_in_ack(src, ok);
      check($sformatf("%s_in_ack", tag), 32'(ok), 32'd1);
    end
    in_ack_seen[src] = ~in_ack_seen[src];
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    tb_in_req  = '0;
    tb_out_ack = '0;
    for (int i = 0; i < 4; i++) tb_in_data[i] = '0;
    repeat (cycles) @(negedge clk);
    check("rst_out_req", 32'(out_req_w), 32'd0);
    check("rst_in_ack", 32'(in_ack_w), 32'd0);
    for (int i = 0; i < 4; i++) check($sformatf("rst_data_p%0d", i), out_data_w[i], 32'd0);
    in_ack_seen  = '0;
    out_req_seen = '0;
    rst = 1'b0;
  endtask

  initial begin : main
    bit          ok;
    int          rr_ptr;
    bit [3:0]    waiting;
    logic [31:0] cflit [4];
    logic [31:0] rf;
    int          src;
    int          pick;

    // Reset held for 200 ns; a req toggle during reset must not propagate.
    tb_in_req  = '0;
    tb_out_ack = '0;
    for (int i = 0; i < 4; i++) tb_in_data[i] = '0;
    repeat (5) @(negedge clk);
    tb_in_data[0] = 32'h4FFF_FFFF;
    tb_in_req[0]  = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_hold_out_req", 32'(out_req_w), 32'd0);
    check("rst_hold_in_ack", 32'(in_ack_w), 32'd0);
    tb_in_req[0] = 1'b0;
    apply_reset(5);

    // Directed routing cases.
    xfer(0, 32'h4FFF_FFFF, "proc_dy");
    xfer(0, 32'h8FFF_FFFE, "proc_dx");
    xfer(0, 32'hCFFF_FFFD, "proc_dxdy");
    xfer(1, 32'h2EEE_EEEE, "p1_local_a");
    xfer(1, 32'h2AAA_AAAA, "p1_local_b");
    xfer(0, 32'hA123_4567, "offmesh_x");
    xfer(0, 32'h5765_4321, "offmesh_y");
    xfer(1, 32'h8000_0001, "p1_to_p1");
    xfer(3, 32'h4000_0003, "p3_dy");

    // Randomised single transfers from every input.
    for (int t = 0; t < 40; t++) begin
      src = $urandom_range(0, 3);
      rf  = $urandom;
      xfer(src, rf, $sformatf("rnd%0d", t));
    end

    // In-flight flit discarded by reset.
    @(negedge clk);
    tb_in_data[0] = 32'h8123_4567;
    tb_in_req[0]  = ~tb_in_req[0];
    wait_out(1, ok);
    check("inflight_req", 32'(ok), 32'd1);
    apply_reset(4);
    repeat (12) @(negedge clk);
    check("inflight_quiet_req", 32'(out_req_w), 32'd0);
    check("inflight_quiet_ack", 32'(in_ack_w), 32'd0);

    // Contention: ports 1..3 all target proc in the same cycle.
    cflit[1] = 32'h1AAA_0001;
    cflit[2] = 32'h2BBB_0002;
    cflit[3] = 32'h3CCC_0003;
    @(negedge clk);
    for (int i = 1; i < 4; i++) begin
      tb_in_data[i] = cflit[i];
      tb_in_req[i]  = ~tb_in_req[i];
    end
    waiting = 4'b1110;
    rr_ptr  = 0;
    for (int k = 0; k < 3; k++) begin
      pick = -1;
      for (int j = 0; j < 4; j++) begin
        if (pick < 0 && waiting[(rr_ptr + j) % 4]) pick = (rr_ptr + j) % 4;
      end
      rr_ptr = (pick + 1) % 4;
      waiting[pick] = 1'b0;
      wait_out(0, ok);
      check($sformatf("cont%0d_req", k), 32'(ok), 32'd1);
      check($sformatf("cont%0d_data", k), out_data_w[0], cflit[pick]);
      check($sformatf("cont%0d_early_ack", k), 32'(in_ack_w), 32'(in_ack_seen));
      out_req_seen[0] = ~out_req_seen[0];
      repeat (3) @(negedge clk);
      tb_out_ack[0] = ~tb_out_ack[0];
      wait_in_ack(pick, ok);
      check($sformatf("cont%0d_in_ack_p%0d", k, pick), 32'(ok), 32'd1);
      in_ack_seen[pick] = ~in_ack_seen[pick];
    end
    repeat (10) @(negedge clk);
    check("cont_final_ack", 32'(in_ack_w), 32'(in_ack_seen));
    check("cont_final_req", 32'(out_req_w), 32'(out_req_seen));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
